// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the pipeline controller: stall vectors,
// exception codes, redirect vectors and the multi-cycle FSM encoding.
package mips_ctrl_pkg;

    localparam int STALL_W  = 6;
    localparam int MC_CNT_W = 6;

    // One bit per stage, bit0 = PC ... bit5 = WB; a stalled stage also holds everything upstream.
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_BREAK   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI      = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    localparam logic [31:0] VEC_INT = 32'h0000_0020;
    localparam logic [31:0] VEC_EXC = 32'h0000_0040;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_t;

    // Unknown non-zero codes still land on the general exception vector.
    function automatic logic [31:0] redirect_pc(input logic [31:0] code,
                                                input logic [31:0] epc);
        logic [31:0] pc;
        case (code)
            EXC_NONE:                                       pc = 32'h0000_0000;
            EXC_INT:                                        pc = VEC_INT;
            EXC_SYSCALL, EXC_BREAK, EXC_RI, EXC_OV, EXC_TRAP: pc = VEC_EXC;
            EXC_ERET:                                       pc = epc;
            default:                                        pc = VEC_EXC;
        endcase
        return pc;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages (master) and the controller (slave).
interface pipe_ctrl_if;
    import mips_ctrl_pkg::*;

    logic                stallreq_if_i;
    logic                stallreq_id_i;
    logic                stallreq_ex_i;
    logic                stallreq_mem_i;
    logic                mc_start_i;
    logic [MC_CNT_W-1:0] mc_cycles_i;
    logic [31:0]         excepttype_i;
    logic [31:0]         cp0_epc_i;

    logic [STALL_W-1:0]  stall_o;
    logic                flush_o;
    logic [31:0]         new_pc_o;
    logic                mc_busy_o;
    logic                mc_done_o;
    logic                mc_abort_o;

    modport master (
        output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        output mc_start_i, mc_cycles_i, excepttype_i, cp0_epc_i,
        input  stall_o, flush_o, new_pc_o, mc_busy_o, mc_done_o, mc_abort_o
    );

    modport slave (
        input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        input  mc_start_i, mc_cycles_i, excepttype_i, cp0_epc_i,
        output stall_o, flush_o, new_pc_o, mc_busy_o, mc_done_o, mc_abort_o
    );

endinterface

// File: rtl/mc_counter.sv
// Down-counter for multi-cycle operations: load, decrement, clear, and
// flags telling the FSM when the last busy cycle has been reached.
module mc_counter
    import mips_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                load,
    input  logic [MC_CNT_W-1:0] load_val,
    input  logic                dec,
    output logic                is_zero,
    output logic                is_one
);

    logic [MC_CNT_W-1:0] count_reg;
    logic [MC_CNT_W-1:0] count_next;

    // Decrement saturates at zero so a stray dec can never wrap to a long op.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (load) begin
            count_next = load_val;
        end else if (dec && (count_reg != '0)) begin
            count_next = count_reg - MC_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign is_zero = (count_reg == '0);
    assign is_one  = (count_reg == MC_CNT_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: prioritised stall vector, exception flush/redirect,
// and the IDLE/BUSY/DONE sequencer for multi-cycle EX operations.
module pipe_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    mc_state_t           state_reg;
    mc_state_t           state_next;
    logic                abort_reg;
    logic                abort_next;

    logic                flush;
    logic                start_ok;
    logic                busy;
    logic [STALL_W-1:0]  stall;

    logic                cnt_clear;
    logic                cnt_load;
    logic                cnt_dec;
    logic [MC_CNT_W-1:0] cnt_load_val;
    logic                cnt_zero;
    logic                cnt_one;

    assign flush    = (bus.excepttype_i != EXC_NONE);
    assign start_ok = bus.mc_start_i && !flush;
    assign busy     = (state_reg == MC_BUSY);

    // A zero-length request still occupies EX for one cycle.
    assign cnt_load_val = (bus.mc_cycles_i == '0) ? MC_CNT_W'(1) : bus.mc_cycles_i;

    mc_counter u_mc_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .is_zero  (cnt_zero),
        .is_one   (cnt_one)
    );

    always_comb begin
        state_next = state_reg;
        abort_next = 1'b0;
        cnt_clear  = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state_reg)
            MC_IDLE, MC_DONE: begin
                if (start_ok) begin
                    state_next = MC_BUSY;
                    cnt_load   = 1'b1;
                end else begin
                    state_next = MC_IDLE;
                end
            end
            MC_BUSY: begin
                if (flush) begin
                    state_next = MC_IDLE;
                    abort_next = 1'b1;
                    cnt_clear  = 1'b1;
                end else if (cnt_one || cnt_zero) begin
                    state_next = MC_DONE;
                    cnt_dec    = 1'b1;
                end else begin
                    cnt_dec    = 1'b1;
                end
            end
            default: begin
                state_next = MC_IDLE;
                cnt_clear  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= MC_IDLE;
            abort_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            abort_reg <= abort_next;
        end
    end

    // Highest-priority source wins; a flush releases every stage.
    always_comb begin
        stall = STALL_NONE;
        if (flush) begin
            stall = STALL_NONE;
        end else if (bus.stallreq_mem_i) begin
            stall = STALL_MEM;
        end else if (bus.stallreq_ex_i || busy) begin
            stall = STALL_EX;
        end else if (bus.stallreq_id_i) begin
            stall = STALL_ID;
        end else if (bus.stallreq_if_i) begin
            stall = STALL_IF;
        end
    end

    assign bus.stall_o    = stall;
    assign bus.flush_o    = flush;
    assign bus.new_pc_o   = redirect_pc(bus.excepttype_i, bus.cp0_epc_i);
    assign bus.mc_busy_o  = busy;
    assign bus.mc_done_o  = (state_reg == MC_DONE);
    assign bus.mc_abort_o = abort_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each driven cycle pushes its expected
// outputs, and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if bus_if ();

    pipe_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        int unsigned id;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        busy;
        logic        done;
        logic        abort;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int unsigned step_id = 0;

    // Reference state: remaining busy cycles and one-cycle pulses due next cycle.
    int          m_left = 0;
    bit          m_done = 1'b0;
    bit          m_abort = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_pc(input logic [31:0] code, input logic [31:0] epc);
        if (code == 32'h0) return 32'h0;
        if (code == 32'h1) return 32'h20;
        if (code == 32'he) return epc;
        return 32'h40;
    endfunction

    function automatic logic [5:0] exp_stall(input bit fl, input bit mem, input bit ex,
                                             input bit bsy, input bit id, input bit ifr);
        if (fl)        return 6'b000000;
        if (mem)       return 6'b011111;
        if (ex || bsy) return 6'b001111;
        if (id)        return 6'b000111;
        if (ifr)       return 6'b000011;
        return 6'b000000;
    endfunction

    task automatic step(input bit r, input bit s_if, input bit s_id, input bit s_ex,
                        input bit s_mem, input bit st, input logic [5:0] cyc,
                        input logic [31:0] exc, input logic [31:0] epc);
        exp_t e;
        rst                   = r;
        bus_if.stallreq_if_i  = s_if;
        bus_if.stallreq_id_i  = s_id;
        bus_if.stallreq_ex_i  = s_ex;
        bus_if.stallreq_mem_i = s_mem;
        bus_if.mc_start_i     = st;
        bus_if.mc_cycles_i    = cyc;
        bus_if.excepttype_i   = exc;
        bus_if.cp0_epc_i      = epc;
        e.id     = step_id;
        e.flush  = (exc != 32'h0);
        e.busy   = (m_left > 0);
        e.done   = m_done;
        e.abort  = m_abort;
        e.stall  = exp_stall(exc != 32'h0, s_mem, s_ex, m_left > 0, s_id, s_if);
        e.new_pc = exp_pc(exc, epc);
        sb_q.push_back(e);
        step_id++;
        @(posedge clk);
        if (r) begin
            m_left = 0; m_done = 1'b0; m_abort = 1'b0;
        end else if (m_left > 0) begin
            if (exc != 32'h0) begin
                m_left = 0; m_done = 1'b0; m_abort = 1'b1;
            end else begin
                m_left--; m_done = (m_left == 0); m_abort = 1'b0;
            end
        end else begin
            m_done = 1'b0; m_abort = 1'b0;
            if (st && exc == 32'h0) m_left = (cyc == 6'd0) ? 1 : int'(cyc);
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 6'd0, 32'h0, 32'h0);
    endtask

    task automatic start_op(input logic [5:0] cyc);
        step(0, 0, 0, 0, 0, 1, cyc, 32'h0, 32'h0);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check($sformatf("stall#%0d", mon_e.id),  {26'h0, bus_if.stall_o},   {26'h0, mon_e.stall});
            check($sformatf("flush#%0d", mon_e.id),  {31'h0, bus_if.flush_o},   {31'h0, mon_e.flush});
            check($sformatf("new_pc#%0d", mon_e.id), bus_if.new_pc_o,           mon_e.new_pc);
            check($sformatf("busy#%0d", mon_e.id),   {31'h0, bus_if.mc_busy_o}, {31'h0, mon_e.busy});
            check($sformatf("done#%0d", mon_e.id),   {31'h0, bus_if.mc_done_o}, {31'h0, mon_e.done});
            check($sformatf("abort#%0d", mon_e.id),  {31'h0, bus_if.mc_abort_o},{31'h0, mon_e.abort});
        end
    end

    logic [31:0] codes [8];
    initial begin
        codes = '{32'h1, 32'h8, 32'h9, 32'ha, 32'hc, 32'hd, 32'he, 32'h1f};
        rst = 1'b1;
        bus_if.stallreq_if_i = 0; bus_if.stallreq_id_i = 0; bus_if.stallreq_ex_i = 0;
        bus_if.stallreq_mem_i = 0; bus_if.mc_start_i = 0; bus_if.mc_cycles_i = '0;
        bus_if.excepttype_i = '0; bus_if.cp0_epc_i = '0;
        @(posedge clk); #1;

        // Reset: combinational outputs follow inputs, registered ones stay clear.
        step(1, 0, 0, 0, 0, 0, 6'd0, 32'h0, 32'h0);
        step(1, 0, 0, 0, 1, 1, 6'd3, 32'h1, 32'h0);
        idle(1);

        // Single and combined stall requests.
        step(0, 1, 0, 0, 0, 0, 6'd0, 32'h0, 32'h0);
        step(0, 1, 1, 0, 0, 0, 6'd0, 32'h0, 32'h0);
        step(0, 1, 1, 1, 0, 0, 6'd0, 32'h0, 32'h0);
        step(0, 1, 1, 1, 1, 0, 6'd0, 32'h0, 32'h0);

        // Four-cycle op, done at T+5.
        start_op(6'd4); idle(6);

        // MEM request mid-op does not pause the countdown.
        start_op(6'd4); idle(1);
        step(0, 0, 0, 0, 1, 0, 6'd0, 32'h0, 32'h0);
        idle(4);

        // ERET flush mid-op aborts it.
        start_op(6'd4); idle(1);
        step(0, 0, 0, 0, 0, 0, 6'd0, 32'he, 32'h8000_1234);
        idle(5);

        // Interrupt overrides a MEM stall; every exception code's vector.
        step(0, 0, 0, 0, 1, 0, 6'd0, 32'h1, 32'h0);
        foreach (codes[i]) step(0, 1, 0, 0, 0, 0, 6'd0, codes[i], 32'hdead_beef);

        // Flush coincident with start in IDLE drops the start.
        step(0, 0, 0, 0, 0, 1, 6'd3, 32'h8, 32'h0);
        idle(3);

        // Start while busy is ignored; start in DONE chains a new op.
        start_op(6'd2); start_op(6'd5); idle(1);
        start_op(6'd1); idle(3);

        // Zero length behaves as one cycle; max length op.
        start_op(6'd0); idle(3);
        start_op(6'd63); idle(64);

        // Reset in BUSY with a zero-length start on the same edge.
        start_op(6'd3); idle(1);
        step(1, 0, 0, 0, 0, 1, 6'd0, 32'h0, 32'h0);
        idle(4);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            step(($urandom % 60) == 0,
                 ($urandom % 6) == 0, ($urandom % 6) == 0,
                 ($urandom % 8) == 0, ($urandom % 8) == 0,
                 ($urandom % 4) == 0, 6'($urandom % 8),
                 (($urandom % 14) == 0) ? codes[$urandom % 8] : 32'h0,
                 $urandom);
        end
        idle(2);

        @(negedge clk); #1;
        check("sb_drain", sb_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 stallreq_if_i  input  1  fetch stage requests stall.
REQ-004 stallreq_id_i  input  1  decode stage requests stall (load-use).
REQ-005 stallreq_ex_i  input  1  execute stage requests stall.
REQ-006 stallreq_mem_i  input  1  memory stage requests stall.
REQ-007 mc_start_i  input  1  one-cycle pulse from EX: start a multi-cycle op.
REQ-008 mc_cycles_i  input  6  multi-cycle op length in cycles, sampled with mc_start_i.
REQ-009 excepttype_i  input  32  exception code from MEM; zero = none.
REQ-010 cp0_epc_i  input  32  return address used for ERET.
REQ-011 stall_o  output  6  per-stage hold; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = stop.
REQ-012 flush_o  output  1  clear all pipeline registers this cycle.
REQ-013 new_pc_o  output  32  redirect target, valid while flush_o=1.
REQ-014 mc_busy_o  output  1  multi-cycle op in progress.
REQ-015 mc_done_o  output  1  one-cycle pulse: op completed, EX captures result.
REQ-016 mc_abort_o  output  1  one-cycle pulse: op cancelled by flush.

Function
REQ-017 Stall vectors SHALL be: IF req 6'b000011, ID req 6'b000111, EX req or busy 6'b001111, MEM req 6'b011111, none 6'b000000.
REQ-018 stall_o SHALL be combinational and equal the vector of the highest-priority active source: flush > MEM > EX/busy > ID > IF.
REQ-019 flush_o SHALL be combinational: 1 iff excepttype_i != 0; when flush_o=1, stall_o SHALL be 6'b000000.
REQ-020 new_pc_o SHALL be: 0x00000020 for code 0x1 (interrupt); 0x00000040 for 0x8, 0x9, 0xa, 0xc, 0xd; cp0_epc_i for 0xe (ERET); 0x00000040 for any other non-zero code; 0 when excepttype_i=0.
REQ-021 FSM states: IDLE, BUSY, DONE.
REQ-022 IDLE: mc_start_i=1 and no flush -> load counter with mc_cycles_i (0 treated as 1), go BUSY next cycle.
REQ-023 BUSY: mc_busy_o=1; counter decrements each cycle; counter==1 -> DONE next cycle.
REQ-024 DONE: mc_done_o=1 for exactly one cycle, mc_busy_o=0, stall_o from requests only; -> IDLE; mc_start_i in DONE starts new op (-> BUSY).
REQ-025 Stall latency: op started at cycle T with N cycles SHALL hold EX stall for cycles T+1..T+N, mc_done_o at T+N+1.
REQ-026 mc_start_i while BUSY SHALL be ignored.
REQ-027 Flush while BUSY SHALL force IDLE next cycle, pulse mc_abort_o that next cycle, never pulse mc_done_o for that op.
REQ-028 Flush coincident with mc_start_i in IDLE SHALL drop the start; no abort pulse.
REQ-029 stallreq_mem_i during BUSY SHALL yield 6'b011111 and not pause the counter.

Reset
REQ-030 rst=1 SHALL force IDLE, counter 0, mc_busy_o=0, mc_done_o=0, mc_abort_o=0 at next edge, overriding flush and mc_start_i.
REQ-031 Combinational outputs (stall_o, flush_o, new_pc_o) SHALL follow inputs during reset; BUSY contribution removed after the reset edge.

Structure
REQ-032 Stall vectors, exception codes, vector addresses, FSM state encoding SHALL reside in shared package mips_ctrl_pkg.
REQ-033 The countdown SHALL be a sub-module mc_counter (load, decrement, zero/one flags); priority logic and FSM stay in pipe_ctrl.

Verification
REQ-034 stallreq_id_i=1 and stallreq_if_i=1 -> stall_o=6'b000111, flush_o=0.
REQ-035 mc_start_i at T, mc_cycles_i=4 -> stall_o=6'b001111 T+1..T+4, mc_done_o=1 only at T+5, mc_busy_o=0 at T+5.
REQ-036 BUSY with stallreq_mem_i=1 at T+2 of 4-cycle op -> stall_o=6'b011111 at T+2, mc_done_o still at T+5.
REQ-037 excepttype_i=0xe, cp0_epc_i=0x8000_1234 during BUSY -> flush_o=1, new_pc_o=0x8000_1234, stall_o=0; next cycle mc_abort_o=1, mc_busy_o=0.
REQ-038 excepttype_i=0x1 with stallreq_mem_i=1 -> flush_o=1, new_pc_o=0x00000020, stall_o=6'b000000.
REQ-039 rst=1 in BUSY with mc_cycles_i=0 start on same edge -> IDLE, no done, no abort after edge.
